// File: rtl/reg_file_ctrl_pkg.sv
// Shared definitions for the register-file command sequencer: default widths,
// opcode encodings, FSM state type and operand-usage helpers.
package reg_file_ctrl_pkg;

    localparam int DW_DEF = 16;
    localparam int IW_DEF = 3;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EX   = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // Every op except LDI consumes operand A.
    function automatic logic uses_a(input logic [2:0] op);
        return (op != OP_LDI);
    endfunction

    // MOV and LDI are the only ops that leave operand B unused.
    function automatic logic uses_b(input logic [2:0] op);
        return !((op == OP_LDI) || (op == OP_MOV));
    endfunction

endpackage

// File: rtl/rf_alu.sv
// rf_alu: purely combinational ALU for the register-file sequencer.
// Produces the result plus zero and carry/borrow; carry is only meaningful
// for ADD/SUB/CMP and is forced low for every other op.
module rf_alu
    import reg_file_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] result,
    output logic          z,
    output logic          c
);

    logic [DW:0] sum;
    logic [DW:0] diff;

    // One extra bit catches the carry out of ADD and the borrow out of SUB/CMP.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Opcode decode into result and carry
    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        result = '0;
        c      = 1'b0;
        case (op)
            OP_MOV: result = a;
            OP_ADD: begin
                result = sum[DW-1:0];
                c      = sum[DW];
            end
            OP_SUB, OP_CMP: begin
                result = diff[DW-1:0];
                c      = diff[DW];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_LDI: result = imm;
            default: result = '0;
        endcase
    end

    assign z = (result == '0);

endmodule

// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: sequences one decoded command through read, execute and
// write-back against an 8x16 register file (IDLE -> RD -> EX -> WB).
// Optional build macro RF_R0_ZERO_EN: register 0 reads as zero (its read
// enable stays low) and write-back to register 0 is suppressed.
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [IW-1:0] cmd_dst,
    input  logic [IW-1:0] cmd_srcA,
    input  logic [IW-1:0] cmd_srcB,
    input  logic [DW-1:0] cmd_imm,
    output logic [IW-1:0] AR_idx,
    output logic [IW-1:0] BR_idx,
    output logic          rdAR_en,
    output logic          rdBR_en,
    input  logic [DW-1:0] rdAR_dat,
    input  logic [DW-1:0] rdBR_dat,
    output logic [IW-1:0] wr_idx,
    output logic          wr_en,
    output logic [DW-1:0] wr_dat,
    output logic          res_valid,
    output logic [DW-1:0] res_dat,
    output logic          flag_z,
    output logic          flag_c
);

    state_t        state;
    state_t        state_nxt;

    logic [2:0]    op_q;
    logic [IW-1:0] dst_q;
    logic [IW-1:0] src_a_q;
    logic [IW-1:0] src_b_q;
    logic [DW-1:0] imm_q;

    logic [DW-1:0] opnd_a_q;
    logic [DW-1:0] opnd_b_q;
    logic [DW-1:0] result_q;

    logic [DW-1:0] alu_result;
    logic          alu_z;
    logic          alu_c;

    logic          need_a;
    logic          need_b;
    logic          write_ok;

    // State register; reset returns to IDLE from any state, aborting the command
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Which operands the latched command reads, and whether it writes back
    always_comb begin
        need_a   = uses_a(op_q);
        need_b   = uses_b(op_q);
        write_ok = (op_q != OP_CMP);
`ifdef RF_R0_ZERO_EN
        if (src_a_q == '0) need_a = 1'b0;
        if (src_b_q == '0) need_b = 1'b0;
        if (dst_q == '0)   write_ok = 1'b0;
`endif
    end

    // Next state and all register-file/handshake outputs, decoded from state
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        AR_idx    = '0;
        BR_idx    = '0;
        rdAR_en   = 1'b0;
        rdBR_en   = 1'b0;
        wr_idx    = '0;
        wr_en     = 1'b0;
        wr_dat    = '0;
        res_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = ST_RD;
            end
            ST_RD: begin
                AR_idx    = src_a_q;
                BR_idx    = src_b_q;
                rdAR_en   = need_a;
                rdBR_en   = need_b;
                state_nxt = ST_EX;
            end
            ST_EX: begin
                state_nxt = ST_WB;
            end
            ST_WB: begin
                wr_en     = write_ok;
                wr_idx    = dst_q;
                wr_dat    = result_q;
                res_valid = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Latch the command fields on the accepting handshake
    always_ff @(posedge clk) begin
        // NOTE: command and operand registers carry no reset; each is always
        // written before the FSM reaches a state that reads it.
        if (cmd_valid && cmd_ready) begin
            op_q    <= cmd_op;
            dst_q   <= cmd_dst;
            src_a_q <= cmd_srcA;
            src_b_q <= cmd_srcB;
            imm_q   <= cmd_imm;
        end
    end

    // Capture operands at the end of RD; an unread port yields 0, not bus junk
    always_ff @(posedge clk) begin
        if (state == ST_RD) begin
            opnd_a_q <= rdAR_en ? rdAR_dat : '0;
            opnd_b_q <= rdBR_en ? rdBR_dat : '0;
        end
    end

    rf_alu #(
        .DW (DW)
    ) u_alu (
        .op     (op_q),
        .a      (opnd_a_q),
        .b      (opnd_b_q),
        .imm    (imm_q),
        .result (alu_result),
        .z      (alu_z),
        .c      (alu_c)
    );

    // Register the ALU result and flags at the end of EX; they hold until the next EX
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
        end else if (state == ST_EX) begin
            result_q <= alu_result;
            flag_z   <= alu_z;
            flag_c   <= alu_c;
        end
    end

    assign res_dat = result_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Self-checking bench for reg_file_ctrl: directed scenarios followed by random
// commands, checked against an array-based register-file reference model.
`timescale 1ns/1ps
module tb_reg_file_ctrl;
    import reg_file_ctrl_pkg::*;

    localparam int DW = 16;
    localparam int IW = 3;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  dst;
        logic [2:0]  sa;
        logic [2:0]  sb;
        logic [15:0] imm;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [IW-1:0] cmd_dst = '0;
    logic [IW-1:0] cmd_srcA = '0;
    logic [IW-1:0] cmd_srcB = '0;
    logic [DW-1:0] cmd_imm = '0;
    logic [IW-1:0] AR_idx, BR_idx, wr_idx;
    logic          rdAR_en, rdBR_en, wr_en, res_valid, flag_z, flag_c;
    logic [DW-1:0] rdAR_dat, rdBR_dat, wr_dat, res_dat;

    // Bench-side register file, written by the DUT or by preload
    logic [15:0]   rf [8];
    logic          pre_we = 1'b0;
    logic [2:0]    pre_idx = '0;
    logic [15:0]   pre_dat = '0;

    // Reference model state and per-command expectations
    logic [15:0]   mdl [8];
    cmd_t          cur, nxt;
    logic [15:0]   exp_res;
    logic          exp_z, exp_c, exp_we, exp_ena, exp_enb;

    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en)       rf[wr_idx]  <= wr_dat;
        else if (pre_we) rf[pre_idx] <= pre_dat;
    end

    // Undriven read ports present junk rather than a real register value
    assign rdAR_dat = rdAR_en ? rf[AR_idx] : 16'hDEAD;
    assign rdBR_dat = rdBR_en ? rf[BR_idx] : 16'hBEEF;

    reg_file_ctrl #(.DW(DW), .IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_srcA  (cmd_srcA),
        .cmd_srcB  (cmd_srcB),
        .cmd_imm   (cmd_imm),
        .AR_idx    (AR_idx),
        .BR_idx    (BR_idx),
        .rdAR_en   (rdAR_en),
        .rdBR_en   (rdBR_en),
        .rdAR_dat  (rdAR_dat),
        .rdBR_dat  (rdBR_dat),
        .wr_idx    (wr_idx),
        .wr_en     (wr_en),
        .wr_dat    (wr_dat),
        .res_valid (res_valid),
        .res_dat   (res_dat),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [2:0] op, input logic [2:0] dst,
                                input logic [2:0] sa, input logic [2:0] sb,
                                input logic [15:0] imm);
        cmd_t c;
        c.op = op; c.dst = dst; c.sa = sa; c.sb = sb; c.imm = imm;
        return c;
    endfunction

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_dat = val;
        mdl[idx] = val;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic drive(input cmd_t c);
        cmd_op = c.op; cmd_dst = c.dst; cmd_srcA = c.sa; cmd_srcB = c.sb; cmd_imm = c.imm;
        cmd_valid = 1'b1;
    endtask

    // Architectural result of a command, computed from the model registers
    task automatic predict(input cmd_t c);
        int unsigned a, b, r;
        exp_ena = (c.op != OP_LDI);
        exp_enb = (c.op != OP_LDI) && (c.op != OP_MOV);
`ifdef RF_R0_ZERO_EN
        if (c.sa == 3'd0) exp_ena = 1'b0;
        if (c.sb == 3'd0) exp_enb = 1'b0;
`endif
        a = exp_ena ? 32'(mdl[c.sa]) : 32'd0;
        b = exp_enb ? 32'(mdl[c.sb]) : 32'd0;
        exp_c = 1'b0;
        case (c.op)
            OP_MOV: r = a;
            OP_ADD: begin r = a + b; exp_c = (r > 32'hFFFF); end
            OP_SUB, OP_CMP: begin r = a - b; exp_c = (a < b); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: r = 32'(c.imm);
        endcase
        exp_res = 16'(r & 32'hFFFF);
        exp_z   = (exp_res == 16'd0);
        exp_we  = (c.op != OP_CMP);
`ifdef RF_R0_ZERO_EN
        if (c.dst == 3'd0) exp_we = 1'b0;
`endif
        cur = c;
    endtask

    // Wait (bounded) for the controller to be free, then present a command
    task automatic issue(input cmd_t c);
        int waited = 0;
        while (cmd_ready !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", 32'(cmd_ready), 32'd1);
        drive(c);
        predict(c);
    endtask

    // Walk RD, EX and WB of the accepted command; keep_valid presents nxt while busy
    task automatic follow(input bit keep_valid);
        @(negedge clk);
        if (keep_valid) drive(nxt);
        else            cmd_valid = 1'b0;
        check("rd_ready",  32'(cmd_ready), 32'd0);
        check("rd_ar_idx", 32'(AR_idx), 32'(cur.sa));
        check("rd_br_idx", 32'(BR_idx), 32'(cur.sb));
        check("rd_ar_en",  32'(rdAR_en), 32'(exp_ena));
        check("rd_br_en",  32'(rdBR_en), 32'(exp_enb));
        check("rd_wr_en",  32'(wr_en), 32'd0);
        check("rd_res_v",  32'(res_valid), 32'd0);
        @(negedge clk);
        check("ex_ready",  32'(cmd_ready), 32'd0);
        check("ex_idx",    32'({AR_idx, BR_idx}), 32'd0);
        check("ex_en",     32'({rdAR_en, rdBR_en}), 32'd0);
        check("ex_wr",     32'({wr_en, wr_idx}), 32'd0);
        check("ex_wr_dat", 32'(wr_dat), 32'd0);
        check("ex_res_v",  32'(res_valid), 32'd0);
        @(negedge clk);
        check("wb_ready",  32'(cmd_ready), 32'd0);
        check("wb_wr_en",  32'(wr_en), 32'(exp_we));
        check("wb_wr_idx", 32'(wr_idx), 32'(cur.dst));
        check("wb_wr_dat", 32'(wr_dat), 32'(exp_res));
        check("wb_res_v",  32'(res_valid), 32'd1);
        check("wb_res",    32'(res_dat), 32'(exp_res));
        check("wb_flag_z", 32'(flag_z), 32'(exp_z));
        check("wb_flag_c", 32'(flag_c), 32'(exp_c));
        check("wb_en",     32'({rdAR_en, rdBR_en}), 32'd0);
        if (exp_we) mdl[cur.dst] = exp_res;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_wr",    32'({wr_en, wr_idx}), 32'd0);
        check("rst_wrdat", 32'(wr_dat), 32'd0);
        check("rst_res",   32'({res_valid, res_dat}), 32'd0);
        check("rst_flags", 32'({flag_z, flag_c}), 32'd0);
        check("rst_rd",    32'({rdAR_en, rdBR_en, AR_idx, BR_idx}), 32'd0);

        for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));

        // Load immediate: no reads, write 3 cycles after accept
        issue(mk(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h1234));
        follow(0);

        // Carry out of ADD with zero result
        preload(3'd1, 16'hFFFF);
        preload(3'd2, 16'h0001);
        issue(mk(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0));
        follow(0);

        // Reset during EX of an ADD: no write, ready next cycle, flags cleared
        issue(mk(OP_ADD, 3'd3, 3'd1, 3'd1, 16'h0));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_rd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_ready", 32'(cmd_ready), 32'd1);
        check("mid_wr_en", 32'(wr_en), 32'd0);
        check("mid_flags", 32'({flag_z, flag_c}), 32'd0);
        check("mid_res",   32'({res_valid, res_dat}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_no_wr", 32'(wr_en), 32'd0);
        end

        // Compare: flags and result only, no write-back
        preload(3'd4, 16'h0005);
        preload(3'd5, 16'h0007);
        issue(mk(OP_CMP, 3'd6, 3'd4, 3'd5, 16'h0));
        follow(0);

        // Back-to-back with cmd_valid held; second reads the first's destination
        issue(mk(OP_ADD, 3'd6, 3'd4, 3'd5, 16'h0));
        nxt = mk(OP_SUB, 3'd7, 3'd6, 3'd4, 16'h0);
        follow(1);
        @(negedge clk);
        check("b2b_ready", 32'(cmd_ready), 32'd1);
        predict(nxt);
        follow(0);

`ifdef RF_R0_ZERO_EN
        // Register 0 reads as zero and is never written
        preload(3'd0, 16'hABCD);
        issue(mk(OP_MOV, 3'd0, 3'd0, 3'd0, 16'h0));
        follow(0);
`endif

        // Random commands against the model
        for (int i = 0; i < 40; i++) begin
            issue(mk(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     16'($urandom)));
            follow(0);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
- Command sequencer that drives the 8x16 register file's access port from the initiator side.
- Accepts one decoded ALU/move command per handshake, then:
  - reads up to two source registers through the A/B read ports,
  - computes the result in an internal ALU,
  - writes the result back through the write port.
- Sits between the instruction decoder and the register file in the simple CPU datapath.

Parameters:
- DW, 16, data width; must match the register file word width.
- IW, 3, register index width (8 registers).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  opcode (see Behaviour)
- cmd_dst  in  IW  destination register index
- cmd_srcA  in  IW  source A register index
- cmd_srcB  in  IW  source B register index
- cmd_imm  in  DW  immediate for LDI
- AR_idx  out  IW  register file read port A index
- BR_idx  out  IW  register file read port B index
- rdAR_en  out  1  read port A enable
- rdBR_en  out  1  read port B enable
- rdAR_dat  in  DW  read port A data; high-Z when rdAR_en low
- rdBR_dat  in  DW  read port B data; high-Z when rdBR_en low
- wr_idx  out  IW  write index
- wr_en  out  1  write enable, one-cycle pulse
- wr_dat  out  DW  write data
- res_valid  out  1  one-cycle pulse, command retired
- res_dat  out  DW  result of retired command
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow flag

Behaviour:
- FSM states: IDLE, RD, EX, WB.
- Transitions:
  - IDLE to RD on cmd_valid && cmd_ready; all cmd_* fields latched.
  - RD to EX, EX to WB, WB to IDLE unconditionally.
- cmd_ready = (state == IDLE). Throughput: one command per 4 cycles.
- Latency: wr_en and res_valid assert in the 3rd cycle after the accepting edge (the WB cycle).
- RD state:
  - AR_idx = srcA, BR_idx = srcB.
  - rdAR_en high only if the op uses A; rdBR_en high only if the op uses B.
  - Operand registers capture rdAR_dat/rdBR_dat at the end of RD.
  - An operand whose enable was low captures 0, never the high-Z value.
- Outside RD: AR_idx = BR_idx = 0, rdAR_en = rdBR_en = 0.
- Opcodes:
  - 000 MOV: A
  - 001 ADD: A+B; carry = bit DW of the (DW+1)-bit sum
  - 010 SUB: A-B; carry = borrow (A<B unsigned)
  - 011 AND
  - 100 OR
  - 101 XOR
  - 110 LDI: imm; no reads
  - 111 CMP: A-B; flags only, no write-back
- EX state:
  - Result registered.
  - flag_z updated for all ops.
  - flag_c updated for ADD/SUB/CMP only; cleared for logic, MOV and LDI.
- WB state:
  - wr_en = 1 except for CMP; wr_idx = dst, wr_dat = result.
  - res_valid = 1, res_dat = result; res_dat holds its value until the next WB.
- Outside WB: wr_en = 0, wr_idx = 0, wr_dat = 0.
- dst equal to a source is legal; the read completes before the write.
- Reset values: state IDLE, cmd_ready = 1 (from the first cycle after reset), all other outputs 0, flags 0.
- rst asserted mid-command (any state): return to IDLE at that edge with no write. wr_en is never asserted in the cycle following a reset edge.
- Commands offered while busy are ignored; the upstream block holds cmd_valid until cmd_ready is seen.

Optional Feature:
- Macro: RF_R0_ZERO_EN.
- Defined:
  - Register 0 is architecturally zero: an operand whose index is 0 reads as 0 regardless of rdAR_dat/rdBR_dat, and its read enable stays low.
  - Write-back to dst 0 is suppressed (wr_en stays 0); res_valid and flags still update.
- Undefined: register 0 behaves as a general register.

Decomposition:
- Package reg_file_ctrl_pkg:
  - opcode localparams OP_MOV..OP_CMP,
  - FSM state encodings,
  - DW/IW defaults.
- One natural sub-module: rf_alu. It is combinational, with op, A, B and imm in, and result, z and c out; instantiated once inside the EX path.

Test Plan:
- Load: LDI dst=1 imm=16'h1234 → wr_en pulse with wr_idx=1, wr_dat=16'h1234 exactly 3 cycles after accept; rdAR_en = rdBR_en = 0 throughout; flag_z=0.
- Carry: R1=16'hFFFF, R2=16'h0001 (rf model preloaded), ADD dst=3 srcA=1 srcB=2 → wr_dat=16'h0000, flag_z=1, flag_c=1; AR_idx=1, BR_idx=2 during RD only.
- Compare: CMP with A=16'h0005, B=16'h0007 → no wr_en, res_valid pulse, res_dat=16'hFFFE, flag_c=1, flag_z=0.
- Back-to-back: cmd_valid held high with two commands → second accepted exactly 4 cycles after the first; cmd_ready low during RD/EX/WB.
- Reset mid-op: rst asserted during EX of ADD → no wr_en ever, cmd_ready=1 the next cycle, flags=0.
- RF_R0_ZERO_EN defined: MOV dst=0 srcA=0 with rf returning 16'hABCD → res_dat=0, flag_z=1, wr_en stays 0.
